// File: rtl/frequency_tracker_sweep_if.sv
// Control and status bundle for frequency_tracker_sweep.
// The master side (controller/plant) drives the i_* signals; the tracker drives the o_* signals.
interface frequency_tracker_sweep_if #(
  parameter int FREQ_W = 32,
  parameter int AMP_W  = 12
);
  logic                     i_enable;
  logic                     i_restart;
  logic signed [AMP_W-1:0]  i_envelope_max;
  logic [FREQ_W-1:0]        o_freq;
  logic                     o_enable;
  logic                     o_locked;
  logic signed [AMP_W-1:0]  o_best_amp;
  logic                     o_level_done;
  logic [3:0]               o_state;

  modport master (
    output i_enable, i_restart, i_envelope_max,
    input  o_freq, o_enable, o_locked, o_best_amp, o_level_done, o_state
  );

  modport slave (
    input  i_enable, i_restart, i_envelope_max,
    output o_freq, o_enable, o_locked, o_best_amp, o_level_done, o_state
  );
endinterface

// File: rtl/frequency_tracker_sweep.sv
// Coarse-to-fine resonance tracker: sweeps 2*HALF_PTS+1 points around a centre, narrows the
// step each accepted level, then holds the best frequency and monitors amplitude for lock loss.
module frequency_tracker_sweep #(
  parameter int FREQ_W        = 32,
  parameter int AMP_W         = 12,
  parameter int HALF_PTS      = 5,
  parameter int MID_INIT      = 1000,
  parameter int STEP_INIT     = 50,
  parameter int STEP_SHIFT    = 2,
  parameter int STEP_MIN      = 3,
  parameter int FREQ_MIN      = 1,
  parameter int FREQ_MAX      = 4095,
  parameter int SETTLE_CYC    = 100000000,
  parameter int BLANK_CYC     = 800000,
  parameter int EQ_SETTLE_CYC = 1200000,
  parameter int AVG_LOG2      = 2,
  parameter int DROP_TH       = 200,
  parameter int EQ_TH         = 150
) (
  input logic i_clk,
  input logic i_rst,
  frequency_tracker_sweep_if.slave bus
);

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_SET        = 4'd1;
  localparam logic [3:0] ST_SETTLE     = 4'd2;
  localparam logic [3:0] ST_SAMPLE     = 4'd3;
  localparam logic [3:0] ST_BLANK      = 4'd4;
  localparam logic [3:0] ST_EVAL       = 4'd5;
  localparam logic [3:0] ST_EQ_SET     = 4'd6;
  localparam logic [3:0] ST_EQ_SETTLE  = 4'd7;
  localparam logic [3:0] ST_EQ_MONITOR = 4'd8;

  localparam int WIDE_W = FREQ_W + 8;
  localparam int IDX_W  = $clog2(HALF_PTS + 1) + 1;
  localparam int ACC_W  = AMP_W + AVG_LOG2;

  localparam logic [31:0] AVG_LAST       = 32'((1 << AVG_LOG2) - 1);
  localparam logic [31:0] SETTLE_LAST    = 32'(SETTLE_CYC - 1);
  localparam logic [31:0] BLANK_LAST     = 32'(BLANK_CYC - 1);
  localparam logic [31:0] EQ_SETTLE_LAST = 32'(EQ_SETTLE_CYC - 1);

  localparam logic signed [IDX_W-1:0]  IDX_FIRST    = IDX_W'(-HALF_PTS);
  localparam logic signed [IDX_W-1:0]  IDX_LAST     = IDX_W'(HALF_PTS);
  localparam logic signed [AMP_W-1:0]  AMP_MOST_NEG = {1'b1, {(AMP_W-1){1'b0}}};
  localparam logic [FREQ_W-1:0]        MID_RST      = FREQ_W'(MID_INIT);
  localparam logic [FREQ_W-1:0]        STEP_RST     = FREQ_W'(STEP_INIT);
  localparam logic [FREQ_W-1:0]        STEP_MIN_W   = FREQ_W'(STEP_MIN);
  localparam logic signed [WIDE_W-1:0] FMIN_W       = WIDE_W'(FREQ_MIN);
  localparam logic signed [WIDE_W-1:0] FMAX_W       = WIDE_W'(FREQ_MAX);

  logic [3:0]               state;
  logic [31:0]              cnt;
  logic signed [ACC_W-1:0]  acc;
  logic signed [IDX_W-1:0]  idx;
  logic [FREQ_W-1:0]        mid;
  logic [FREQ_W-1:0]        step;
  logic signed [AMP_W-1:0]  ref_amp;
  logic signed [AMP_W-1:0]  best;
  logic [FREQ_W-1:0]        best_f;
  logic [FREQ_W-1:0]        freq;

  logic signed [WIDE_W-1:0] mid_wide;
  logic signed [WIDE_W-1:0] point;
  logic signed [ACC_W-1:0]  sum;
  logic signed [AMP_W-1:0]  avg;
  logic [FREQ_W-1:0]        step_next;
  logic                     window_last;
  logic                     accept;
  logic                     drop;
  logic                     out_of_band;
  logic                     full_reload;

  function automatic logic [FREQ_W-1:0] clamp_freq(input logic signed [WIDE_W-1:0] v);
    if (v < FMIN_W)
      return FREQ_W'(FREQ_MIN);
    else if (v > FMAX_W)
      return FREQ_W'(FREQ_MAX);
    else
      return v[FREQ_W-1:0];
  endfunction

  always_comb begin
    mid_wide    = $signed(WIDE_W'(mid));
    point       = mid_wide + WIDE_W'(idx) * $signed(WIDE_W'(step));
    sum         = acc + ACC_W'(bus.i_envelope_max);
    avg         = AMP_W'(sum >>> AVG_LOG2);
    step_next   = step >> STEP_SHIFT;
    window_last = (cnt == AVG_LAST);
    accept      = (best >= ref_amp);
    drop        = (int'(best) + DROP_TH < int'(ref_amp));
    out_of_band = (int'(avg) + EQ_TH < int'(ref_amp)) || (int'(avg) > int'(ref_amp) + EQ_TH);
    // Every path that restarts the coarse search funnels through the same reload
    full_reload = ((state != ST_IDLE) && bus.i_restart) ||
                  ((state == ST_EVAL) && !accept && drop) ||
                  ((state == ST_EQ_MONITOR) && window_last && out_of_band);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      acc     <= '0;
      idx     <= IDX_FIRST;
      mid     <= MID_RST;
      step    <= STEP_RST;
      ref_amp <= '0;
      best    <= AMP_MOST_NEG;
      best_f  <= MID_RST;
      freq    <= MID_RST;
    end else if (!bus.i_enable) begin
      state <= ST_IDLE;
      cnt   <= '0;
      acc   <= '0;
    end else if ((state == ST_IDLE) || full_reload) begin
      state   <= ST_SET;
      cnt     <= '0;
      acc     <= '0;
      idx     <= IDX_FIRST;
      mid     <= MID_RST;
      step    <= STEP_RST;
      ref_amp <= '0;
      best    <= AMP_MOST_NEG;
      best_f  <= MID_RST;
    end else begin
      case (state)
        ST_SET: begin
          freq  <= clamp_freq(point);
          cnt   <= '0;
          state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_SAMPLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_SAMPLE: begin
          if (window_last) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_BLANK;
            if (avg > best) begin
              best   <= avg;
              best_f <= freq;
            end
          end else begin
            acc <= sum;
            cnt <= cnt + 32'd1;
          end
        end
        ST_BLANK: begin
          if (cnt == BLANK_LAST) begin
            cnt <= '0;
            if (idx < IDX_LAST) begin
              idx   <= idx + IDX_W'(1);
              state <= ST_SET;
            end else begin
              state <= ST_EVAL;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_EVAL: begin
          // Drop-out branch is taken by full_reload above; here only accept or repeat
          idx  <= IDX_FIRST;
          best <= AMP_MOST_NEG;
          if (accept) begin
            mid     <= best_f;
            ref_amp <= best;
            step    <= step_next;
            state   <= (step_next < STEP_MIN_W) ? ST_EQ_SET : ST_SET;
          end else begin
            best_f <= mid;
            state  <= ST_SET;
          end
        end
        ST_EQ_SET: begin
          freq  <= clamp_freq(mid_wide);
          cnt   <= '0;
          state <= ST_EQ_SETTLE;
        end
        ST_EQ_SETTLE: begin
          if (cnt == EQ_SETTLE_LAST) begin
            cnt   <= '0;
            state <= ST_EQ_MONITOR;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_EQ_MONITOR: begin
          if (window_last) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            acc <= sum;
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_freq       = freq;
  assign bus.o_enable     = (state != ST_IDLE) && (state != ST_BLANK);
  assign bus.o_locked     = (state == ST_EQ_MONITOR);
  assign bus.o_best_amp   = ref_amp;
  assign bus.o_level_done = (state == ST_EVAL);
  assign bus.o_state      = state;

endmodule

// File: tb/tb_frequency_tracker_sweep.sv
// Bench for frequency_tracker_sweep: a plant model turns o_freq into an envelope peak and a
// plain-loop reference of the coarse-to-fine search predicts sweep points and lock results.
module tb_frequency_tracker_sweep;
  localparam logic [3:0] S_IDLE = 4'd0, S_SET = 4'd1, S_SETTLE = 4'd2, S_SAMPLE = 4'd3,
                         S_BLANK = 4'd4, S_EVAL = 4'd5, S_EQ_MON = 4'd8;
  localparam int PER_POINT = 1 + 4 + 2 + 2;

  logic clk, rst;
  int checks = 0, failures = 0;
  int env_mode = 1, flat_val = 0, pk_f = 1050, pk_a = 1000, pk_s = 2;

  frequency_tracker_sweep_if #(.FREQ_W(32), .AMP_W(12)) bus ();
  frequency_tracker_sweep_if #(.FREQ_W(32), .AMP_W(12)) bus_lo ();

  frequency_tracker_sweep #(.SETTLE_CYC(4), .BLANK_CYC(2), .EQ_SETTLE_CYC(3), .AVG_LOG2(1))
    dut (.i_clk(clk), .i_rst(rst), .bus(bus));

  frequency_tracker_sweep #(.MID_INIT(100), .STEP_INIT(50), .SETTLE_CYC(4), .BLANK_CYC(2),
                            .EQ_SETTLE_CYC(3), .AVG_LOG2(1))
    dut_lo (.i_clk(clk), .i_rst(rst), .bus(bus_lo));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int clampf(input int v);
    return (v < 1) ? 1 : ((v > 4095) ? 4095 : v);
  endfunction

  // Envelope seen by the sensor: flat value, or a triangular resonance peak
  function automatic int env_fn(input int f, input int mode, input int flat, input int pf,
                                input int pa, input int ps);
    int d, v;
    if (mode != 0) return flat;
    d = (f > pf) ? f - pf : pf - f;
    v = pa - ps * d;
    return (v < -2048) ? -2048 : ((v > 2047) ? 2047 : v);
  endfunction

  always_comb bus.i_envelope_max = 12'(env_fn(int'(bus.o_freq), env_mode, flat_val, pk_f, pk_a, pk_s));

  // Reference search: sweep, pick the first maximum, narrow until the step is too small
  task automatic model_search(input int pf, input int pa, input int ps, output int lock_f,
                              output int ref_out);
    int mid, step, refv, best, bf, f, a;
    mid = 1000; step = 50; refv = 0;
    lock_f = -1; ref_out = 0;
    for (int lvl = 0; lvl < 20; lvl++) begin
      best = -2048; bf = mid;
      for (int i = -5; i <= 5; i++) begin
        f = clampf(mid + i * step);
        a = env_fn(f, 0, 0, pf, pa, ps);
        if (a > best) begin best = a; bf = f; end
      end
      if (best < refv) return;
      mid = bf; refv = best; step = step >> 2;
      if (step < 3) begin
        lock_f = clampf(mid); ref_out = refv;
        return;
      end
    end
  endtask

  task automatic wait_state(input logic [3:0] target, input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.o_state == target) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: state %0d, required %0d within %0d cycles", name, bus.o_state, target, budget);
    end
  endtask

  task automatic wait_done(input int budget, input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      if (bus.o_level_done === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: no o_level_done within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst = 1; bus.i_enable = 0; bus.i_restart = 0;
    bus_lo.i_enable = 0; bus_lo.i_restart = 0; bus_lo.i_envelope_max = '0;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_state !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0d expected 0", bus.o_state); end
    checks++; if (bus.o_freq !== 32'd1000) begin failures++; $display("FAIL reset_freq: got %0d expected 1000", bus.o_freq); end
    checks++; if (bus.o_enable !== 1'b0) begin failures++; $display("FAIL reset_enable: got %b expected 0", bus.o_enable); end
    checks++; if (bus.o_locked !== 1'b0) begin failures++; $display("FAIL reset_locked: got %b expected 0", bus.o_locked); end
    checks++; if (bus.o_best_amp !== 12'sd0) begin failures++; $display("FAIL reset_best: got %0d expected 0", bus.o_best_amp); end
    checks++; if (bus.o_level_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", bus.o_level_done); end
    checks++; if (bus_lo.o_freq !== 32'd100) begin failures++; $display("FAIL reset_freq_lo: got %0d expected 100", bus_lo.o_freq); end
    rst = 0;
    @(negedge clk);
    checks++; if (bus.o_state !== S_IDLE) begin failures++; $display("FAIL idle_hold: got %0d expected 0", bus.o_state); end
  endtask

  task automatic test_freq_floor();
    int k;
    logic [3:0] prev;
    k = 0; prev = bus_lo.o_state;
    bus_lo.i_enable = 1;
    for (int cyc = 0; cyc < 300 && k < 11; cyc++) begin
      @(negedge clk);
      if (bus_lo.o_state == S_SETTLE && prev == S_SET) begin
        checks++;
        if (bus_lo.o_freq !== 32'(clampf(100 + (k - 5) * 50))) begin
          failures++;
          $display("FAIL floor_point%0d: got %0d expected %0d", k, bus_lo.o_freq, clampf(100 + (k - 5) * 50));
        end
        k++;
      end
      prev = bus_lo.o_state;
    end
    checks++; if (k != 11) begin failures++; $display("FAIL floor_points: got %0d expected 11", k); end
    bus_lo.i_enable = 0;
  endtask

  task automatic test_sweep_timing();
    int cyc, k, blanks, bad_en;
    logic [3:0] prev;
    env_mode = 0; pk_f = 1050; pk_a = 1000; pk_s = 2;
    bus.i_enable = 1;
    @(negedge clk);
    checks++; if (bus.o_state !== S_SET) begin failures++; $display("FAIL start_set: got %0d expected 1", bus.o_state); end
    cyc = 0; k = 0; blanks = 0; bad_en = 0; prev = S_SET;
    while (bus.o_state !== S_EVAL && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (bus.o_state == S_SETTLE && prev == S_SET) begin
        checks++;
        if (bus.o_freq !== 32'(clampf(1000 + (k - 5) * 50))) begin
          failures++;
          $display("FAIL sweep_point%0d: got %0d expected %0d", k, bus.o_freq, clampf(1000 + (k - 5) * 50));
        end
        k++;
      end
      if (bus.o_state == S_BLANK) begin
        blanks++;
        if (bus.o_enable !== 1'b0) bad_en++;
      end
      prev = bus.o_state;
    end
    checks++; if (cyc != 11 * PER_POINT) begin failures++; $display("FAIL level_cycles: got %0d expected %0d", cyc, 11 * PER_POINT); end
    checks++; if (blanks != 22 || bad_en != 0) begin failures++; $display("FAIL blank_enable: got %0d blank cycles %0d enabled, expected 22 and 0", blanks, bad_en); end
    checks++; if (bus.o_level_done !== 1'b1) begin failures++; $display("FAIL level_done: got %b expected 1", bus.o_level_done); end
    @(negedge clk);
    checks++; if (bus.o_state !== S_SET || bus.o_best_amp !== 12'sd1000) begin failures++; $display("FAIL level1_accept: got state %0d ref %0d expected 1 and 1000", bus.o_state, bus.o_best_amp); end
    @(negedge clk);
    checks++; if (bus.o_freq !== 32'd990) begin failures++; $display("FAIL level2_first: got %0d expected 990", bus.o_freq); end
  endtask

  task automatic test_lock();
    int lock_f, ref_m, d;
    model_search(1050, 1000, 2, lock_f, ref_m);
    wait_state(S_EQ_MON, 400, "lock_wait");
    d = int'(bus.o_freq) - 1050;
    checks++; if (bus.o_freq !== 32'(lock_f) || d > 3 || d < -3) begin failures++; $display("FAIL lock_freq: got %0d expected %0d", bus.o_freq, lock_f); end
    checks++; if (bus.o_locked !== 1'b1 || bus.o_enable !== 1'b1) begin failures++; $display("FAIL lock_flags: got locked %b enable %b expected 1 1", bus.o_locked, bus.o_enable); end
    checks++; if (bus.o_best_amp !== 12'(ref_m)) begin failures++; $display("FAIL lock_ref: got %0d expected %0d", bus.o_best_amp, ref_m); end
    repeat (6) @(negedge clk);
    checks++; if (bus.o_locked !== 1'b1) begin failures++; $display("FAIL lock_hold: got %b expected 1", bus.o_locked); end
  endtask

  task automatic test_lock_loss();
    env_mode = 1; flat_val = 800;
    wait_state(S_SET, 6, "loss_reload");
    checks++; if (bus.o_locked !== 1'b0) begin failures++; $display("FAIL loss_locked: got %b expected 0", bus.o_locked); end
    @(negedge clk);
    checks++; if (bus.o_freq !== 32'd750) begin failures++; $display("FAIL loss_freq: got %0d expected 750", bus.o_freq); end
  endtask

  task automatic test_repeat_level();
    env_mode = 0;
    wait_done(150, "rep_level1");
    env_mode = 1; flat_val = 900;
    @(negedge clk);
    checks++; if (bus.o_best_amp !== 12'sd1000) begin failures++; $display("FAIL rep_ref1: got %0d expected 1000", bus.o_best_amp); end
    @(negedge clk);
    wait_done(150, "rep_level2");
    flat_val = 700;
    @(negedge clk);
    checks++; if (bus.o_state !== S_SET || bus.o_best_amp !== 12'sd1000) begin failures++; $display("FAIL rep_same: got state %0d ref %0d expected 1 and 1000", bus.o_state, bus.o_best_amp); end
    @(negedge clk);
    checks++; if (bus.o_freq !== 32'd990) begin failures++; $display("FAIL rep_first: got %0d expected 990", bus.o_freq); end
    wait_done(150, "rep_level3");
    @(negedge clk);
    checks++; if (bus.o_state !== S_SET || bus.o_best_amp !== 12'sd0) begin failures++; $display("FAIL drop_reload: got state %0d ref %0d expected 1 and 0", bus.o_state, bus.o_best_amp); end
    @(negedge clk);
    checks++; if (bus.o_freq !== 32'd750) begin failures++; $display("FAIL drop_freq: got %0d expected 750", bus.o_freq); end
  endtask

  task automatic test_flat_tie();
    env_mode = 1; flat_val = 500;
    wait_done(150, "tie_level");
    @(negedge clk);
    checks++; if (bus.o_best_amp !== 12'sd500) begin failures++; $display("FAIL tie_ref: got %0d expected 500", bus.o_best_amp); end
    @(negedge clk);
    checks++; if (bus.o_freq !== 32'd690) begin failures++; $display("FAIL tie_lowest: got %0d expected 690", bus.o_freq); end
  endtask

  task automatic test_rst_in_sample();
    wait_state(S_SAMPLE, 20, "rst_wait_sample");
    rst = 1;
    @(negedge clk);
    checks++;
    if (bus.o_state !== S_IDLE || bus.o_freq !== 32'd1000 || bus.o_enable !== 1'b0 ||
        bus.o_locked !== 1'b0 || bus.o_best_amp !== 12'sd0 || bus.o_level_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_sample: got state %0d freq %0d en %b lock %b ref %0d done %b expected 0 1000 0 0 0 0",
               bus.o_state, bus.o_freq, bus.o_enable, bus.o_locked, bus.o_best_amp, bus.o_level_done);
    end
    rst = 0;
  endtask

  task automatic test_restart_in_monitor();
    env_mode = 0; pk_f = 1050; pk_a = 1000; pk_s = 2;
    @(negedge clk);
    wait_state(S_EQ_MON, 400, "restart_wait_lock");
    bus.i_restart = 1;
    @(negedge clk);
    bus.i_restart = 0;
    checks++; if (bus.o_state !== S_SET || bus.o_locked !== 1'b0) begin failures++; $display("FAIL restart_set: got state %0d locked %b expected 1 0", bus.o_state, bus.o_locked); end
    @(negedge clk);
    checks++; if (bus.o_freq !== 32'd750) begin failures++; $display("FAIL restart_freq: got %0d expected 750", bus.o_freq); end
  endtask

  task automatic test_random_lock();
    int lock_f, ref_m;
    for (int n = 0; n < 3; n++) begin
      env_mode = 0;
      pk_f = 900 + int'($urandom_range(0, 250));
      pk_a = 600 + int'($urandom_range(0, 800));
      pk_s = int'($urandom_range(1, 3));
      model_search(pk_f, pk_a, pk_s, lock_f, ref_m);
      bus.i_restart = 1;
      @(negedge clk);
      bus.i_restart = 0;
      wait_state(S_EQ_MON, 600, "rand_lock_wait");
      checks++; if (bus.o_freq !== 32'(lock_f) || bus.o_best_amp !== 12'(ref_m)) begin
        failures++;
        $display("FAIL rand_lock%0d: got freq %0d ref %0d expected %0d %0d (peak %0d amp %0d slope %0d)",
                 n, bus.o_freq, bus.o_best_amp, lock_f, ref_m, pk_f, pk_a, pk_s);
      end
      repeat (4) @(negedge clk);
      checks++; if (bus.o_locked !== 1'b1) begin failures++; $display("FAIL rand_hold%0d: got %b expected 1", n, bus.o_locked); end
    end
  endtask

  task automatic test_disable();
    logic [31:0] f_hold;
    f_hold = bus.o_freq;
    bus.i_enable = 0;
    @(negedge clk);
    checks++; if (bus.o_state !== S_IDLE || bus.o_freq !== f_hold || bus.o_enable !== 1'b0 || bus.o_locked !== 1'b0) begin
      failures++;
      $display("FAIL disable_idle: got state %0d freq %0d en %b lock %b expected 0 %0d 0 0",
               bus.o_state, bus.o_freq, bus.o_enable, bus.o_locked, f_hold);
    end
    bus.i_enable = 1;
    @(negedge clk);
    checks++; if (bus.o_state !== S_SET) begin failures++; $display("FAIL reenable_set: got %0d expected 1", bus.o_state); end
  endtask

  initial begin
    test_reset();
    test_freq_floor();
    test_sweep_timing();
    test_lock();
    test_lock_loss();
    test_repeat_level();
    test_flat_tie();
    test_rst_in_sample();
    test_restart_in_monitor();
    test_random_lock();
    test_disable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frequency_tracker_sweep.md
FREQUENCY_TRACKER_SWEEP -- requirements
Module: frequency_tracker_sweep

Interface
REQ-001 SHALL have parameters: FREQ_W, default 32, frequency word width.
REQ-002 SHALL have parameters: AMP_W, default 12, envelope sample width, signed.
REQ-003 SHALL have parameters: HALF_PTS, default 5, sweep index runs -HALF_PTS..+HALF_PTS (2*HALF_PTS+1 points).
REQ-004 SHALL have parameters: MID_INIT, default 1000, coarse centre frequency; STEP_INIT, default 50, coarse step.
REQ-005 SHALL have parameters: STEP_SHIFT, default 2, step right-shift per level; STEP_MIN, default 3, lock when step < STEP_MIN.
REQ-006 SHALL have parameters: FREQ_MIN, default 1; FREQ_MAX, default 4095, clamp limits for o_freq.
REQ-007 SHALL have parameters: SETTLE_CYC, default 100000000; BLANK_CYC, default 800000; EQ_SETTLE_CYC, default 1200000.
REQ-008 SHALL have parameters: AVG_LOG2, default 2, samples averaged per point = 2^AVG_LOG2.
REQ-009 SHALL have parameters: DROP_TH, default 200, search restart threshold; EQ_TH, default 150, lock-loss threshold.
REQ-010 SHALL have ports: i_clk  in  1  single clock, all logic on rising edge.
REQ-011 SHALL have ports: i_rst  in  1  reset, synchronous, active-high.
REQ-012 SHALL have ports: i_enable  in  1  run; low forces IDLE.
REQ-013 SHALL have ports: i_restart  in  1  one-cycle pulse, restart coarse search.
REQ-014 SHALL have ports: i_envelope_max  in  AMP_W  signed envelope peak.
REQ-015 SHALL have ports: o_freq  out  FREQ_W  drive frequency word.
REQ-016 SHALL have ports: o_enable  out  1  power stage enable.
REQ-017 SHALL have ports: o_locked  out  1  high in EQ_MONITOR only.
REQ-018 SHALL have ports: o_best_amp  out  AMP_W  signed reference amplitude of current level.
REQ-019 SHALL have ports: o_level_done  out  1  one-cycle pulse per completed sweep level.
REQ-020 SHALL have ports: o_state  out  4  state code: IDLE=0,SET=1,SETTLE=2,SAMPLE=3,BLANK=4,EVAL=5,EQ_SET=6,EQ_SETTLE=7,EQ_MONITOR=8.

Function
REQ-021 SHALL, in IDLE, hold o_enable=0, o_locked=0; on i_enable=1 load mid=MID_INIT, step=STEP_INIT, ref=0, idx=-HALF_PTS, best=most negative, best_f=MID_INIT; go SET.
REQ-022 SHALL, in SET, register o_freq = clamp(mid + idx*step) using signed arithmetic of FREQ_W+8 bits, clamp to [FREQ_MIN,FREQ_MAX]; o_enable=1; go SETTLE next cycle.
REQ-023 SHALL, in SETTLE, count to SETTLE_CYC-1 then go SAMPLE with counter cleared.
REQ-024 SHALL, in SAMPLE, accumulate 2^AVG_LOG2 consecutive samples (one per cycle) in AMP_W+AVG_LOG2 signed bits, average by arithmetic shift right AVG_LOG2.
REQ-025 SHALL update best/best_f only when avg > best (strict; ties keep lower index); then go BLANK.
REQ-026 SHALL, in BLANK, drive o_enable=0 for BLANK_CYC cycles, then o_enable=1; if idx < HALF_PTS: idx+1, go SET; else go EVAL.
REQ-027 SHALL, in EVAL (single cycle), pulse o_level_done and take one of three branches:
REQ-028 SHALL, if best >= ref: mid=best_f, ref=best, step=step>>STEP_SHIFT; go EQ_SET when new step < STEP_MIN, else SET with idx=-HALF_PTS, best cleared.
REQ-029 SHALL, if best + DROP_TH < ref: full reload as REQ-021 and go SET.
REQ-030 SHALL, otherwise (within band): repeat same level, keeping mid/step/ref, idx=-HALF_PTS, best cleared; go SET.
REQ-031 SHALL, in EQ_SET, set o_freq=clamp(mid); go EQ_SETTLE; EQ_SETTLE counts EQ_SETTLE_CYC then EQ_MONITOR.
REQ-032 SHALL, in EQ_MONITOR, assert o_locked, average 2^AVG_LOG2 samples per window; if avg + EQ_TH < ref or avg > ref + EQ_TH, full reload (REQ-021) and go SET.
REQ-033 SHALL treat i_restart=1 in any non-IDLE state as full reload and go SET next cycle; i_rst overrides i_restart, i_restart overrides i_enable=1 transitions.
REQ-034 SHALL, on i_enable=0 in any state, go IDLE next cycle, clearing counters; o_freq retains last value.
REQ-035 SHALL reach EVAL after exactly (2*HALF_PTS+1)*(1+SETTLE_CYC+2^AVG_LOG2+BLANK_CYC) cycles from SET with idx=-HALF_PTS.

Reset
REQ-036 SHALL, with i_rst=1 at a clock edge, force state IDLE, o_freq=MID_INIT, o_enable=0, o_locked=0, o_best_amp=0, o_level_done=0, all counters 0, mid-operation included.

Verification (SETTLE_CYC=4, BLANK_CYC=2, EQ_SETTLE_CYC=3, AVG_LOG2=1)
REQ-037 SHALL cover: envelope peak 1000 at f=1050 (falling 100 per 50 away) -> level 1 ref=1000, mid=1050, step=12; lock at o_freq within 3 of 1050, o_locked=1.
REQ-038 SHALL cover: locked with ref=1000, envelope stepped to 800 -> within one averaging window full reload, o_freq=750 in next SET, o_locked=0.
REQ-039 SHALL cover: level-2 best 900 vs ref 1000 (within DROP_TH) -> level repeated, mid/step unchanged, o_level_done pulsed; best 700 -> full reload.
REQ-040 SHALL cover: MID_INIT=100, STEP_INIT=50 -> idx -5..-2 produce o_freq=FREQ_MIN=1, no wrap-around.
REQ-041 SHALL cover: i_rst during SAMPLE, and i_restart during EQ_MONITOR -> reset values next cycle, and SET with o_freq=750 respectively.
REQ-042 SHALL cover: flat envelope 500 at all points -> best_f = lowest point of sweep (tie rule), level accepted.
